axi_mem_slave: RTL and testbench
================================

# axi_mem_slave

AXI4 memory responder that serves the burst traffic issued by the data and instruction cache controllers: line fills (read bursts) and dirty-line writebacks (write bursts). Sits on the far side of `axi_inf` from the caches and backs the address window with on-chip block RAM. It is used as the main-memory model in simulation and as on-chip memory in small FPGA builds. One transaction is in service at a time.

## Interface
- `ADDR_SIZE`, 32: address width; must match the master.
- `MEM_SIZE`, 2**16: bytes of backing store; a power of two, at least 4.
- `BASE_ADDR`, 0: byte address of the first location; aligned to `MEM_SIZE`.
- `i_aclk`  in  1: system clock; single clock domain.
- `i_areset`  in  1: reset, asynchronous and active-high.
- `axi`  `axi_inf.slave`  DATA_SIZE data, ADDR_SIZE address: AW, W, B, AR and R channels (`len`, `size`, `burst`, `strb`, `last`, `resp`).

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP.
- **IDLE**
  - `arready` and `awready` are both high.
  - Only one handshake is accepted per cycle.
  - If `arvalid` and `awvalid` are both high, a round-robin bit decides. After reset the bit favours read, and it toggles after every granted transaction.
  - The non-granted ready drops in that cycle, so the other request is not accepted.
- **Address and burst capture:** `addr`, `len` and the error flag are captured on the handshake.
  - `burst` is ignored; every burst is treated as INCR.
  - `size` is ignored; every beat is treated as 4 bytes (DATA_SIZE/8).
  - Word index = (addr - BASE_ADDR) >> 2, truncated to `$clog2(MEM_SIZE/4)` bits.
  - The error flag is set when addr < BASE_ADDR, or when addr + 4*(len+1) > BASE_ADDR + MEM_SIZE.
- **RD_ADDR:** issues the RAM read for beat 0, then moves to RD_DATA.
- **RD_DATA**
  - `rvalid` stays high until the last beat handshakes.
  - On each `rvalid && rready`, the RAM address advances by one word.
  - `rlast` is high on beat `len`.
  - `rresp` is OKAY (2'b00), or SLVERR (2'b10) on every beat when the error flag is set; `rdata` is then 0.
  - After the last handshake the FSM returns to IDLE.
- **WR_DATA**
  - `wready` is high.
  - Each `wvalid && wready` writes the enabled bytes (`wstrb`) to the current word, then increments the word and the beat counter.
  - When the error flag is set, writes are suppressed but beats are still consumed.
  - The burst ends at beat counter == `len`, regardless of `wlast`. If `wlast` does not match that beat, the error flag is set.
  - After the last beat the FSM moves to WR_RESP.
- **WR_RESP:** `bvalid` is high, with `bresp` = OKAY or SLVERR according to the error flag. On `bready` the FSM returns to IDLE.
- **Reset**
  - Asserting `i_areset` at any time forces IDLE and clears the beat counter, error flag and round-robin bit.
  - All ready and valid outputs drop immediately. A burst in progress is abandoned and no response is produced for it.
  - RAM contents are not cleared.
- **Reset values:** `awready`, `arready`, `wready`, `bvalid`, `rvalid` and `rlast` are 0; `rdata`, `rresp` and `bresp` are 0.

## Timing
- The first readies rise on the first clock edge after `i_areset` deasserts.
- Read: AR handshake at cycle T → beat 0 `rvalid` at T+2. With `rready` held high, throughput is 1 beat per cycle.
- Read backpressure: while `rready` is low, `rdata` and `rlast` hold stable. The RAM address is driven from the next word on a handshake and from the current word otherwise, so no bubble follows `rready` rising.
- Write: AW handshake at T → `wready` from T+1. The last W handshake at U → `bvalid` at U+1.
- Back-to-back: IDLE readies are asserted in the cycle after the final R or B handshake.
- Minimum turnaround between transactions is 1 cycle.
- A 16-beat read with no stalls takes 18 cycles from `arvalid` to the final handshake.

## Structure
- `axi_defines`: add `RESP_OKAY` and `RESP_SLVERR` constants, and an `axi_mem_state_t` enum for the five states.
- `multicore_pkg`: provides DATA_SIZE and is reused unchanged.
- Sub-module `bram_be`: a single-port synchronous-read RAM, depth MEM_SIZE/4 and width DATA_SIZE, with a per-byte write enable.
  - It is needed because the existing `ram` lacks byte enables.
  - Read-during-write to the same address returns the old data.

## Test plan
- **Write/read line:** AW addr 0x100, len 3, data 0xA0..0xA3, full strobes → `bresp` 0. Then AR 0x100, len 3 → beats 0xA0..0xA3 with `rlast` on beat 3, the first `rvalid` 2 cycles after the AR handshake.
- **Byte strobes and backpressure:** write 0x11223344 at 0x40, then write 0xFFFFFFFF there with `wstrb` 4'b0101. Read with `rready` toggling every cycle → 0x11FF33FF held stable across stalls.
- **Arbitration:** `arvalid` and `awvalid` both rise together after reset → the read is granted first, then the write. A repeat of the collision grants the write first.
- **Error window:** AR at BASE_ADDR + MEM_SIZE - 8 with len 3 → 4 beats of `rresp` 2'b10 and `rdata` 0. A write to the same range → `bresp` 2'b10 and memory unchanged.
- **`wlast` mismatch:** AW len 3 with `wlast` on beat 1 → 4 beats accepted and `bresp` 2'b10.
- **Mid-burst reset:** assert `i_areset` during beat 2 of an 8-beat read → `rvalid` drops immediately. After release, `arready` returns high and a new read returns correct data.

Source files
------------

// File: rtl/axi_mem_slave_pkg.sv
// Shared constants and types for the AXI4 memory responder.
package axi_mem_slave_pkg;

  // Beat width of the AXI data channels.
  localparam int unsigned DATA_SIZE = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrData,
    StWrResp
  } axi_mem_state_t;

endpackage

// File: rtl/axi_mem_slave_bram_be.sv
// Single-port synchronous-read RAM with per-byte write enables.
// A read of the address being written returns the old contents.
module axi_mem_slave_bram_be
  import axi_mem_slave_pkg::*;
#(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Width = DATA_SIZE,
  parameter int unsigned AddrW = 10
) (
  input  logic               clk,
  input  logic [AddrW-1:0]   addr,
  input  logic               we,
  input  logic [Width/8-1:0] be,
  input  logic [Width-1:0]   wdata,
  output logic [Width-1:0]   rdata
);

  logic [Width-1:0] mem [Depth];

  // Byte-masked write and registered read on the same address.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < Width / 8; i++) begin
        if (be[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 burst memory responder backed by byte-enabled block RAM.
// Serves one transaction at a time; bursts are INCR with 4-byte beats.
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int unsigned          ADDR_SIZE = 32,
  parameter int unsigned          MEM_SIZE  = 2**16,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0
) (
  input  logic                   i_aclk,
  input  logic                   i_areset,
  // Write address
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [ADDR_SIZE-1:0]   awaddr,
  input  logic [7:0]             awlen,
  input  logic [2:0]             awsize,
  input  logic [1:0]             awburst,
  // Write data
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [DATA_SIZE-1:0]   wdata,
  input  logic [DATA_SIZE/8-1:0] wstrb,
  input  logic                   wlast,
  // Write response
  output logic                   bvalid,
  input  logic                   bready,
  output logic [1:0]             bresp,
  // Read address
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [ADDR_SIZE-1:0]   araddr,
  input  logic [7:0]             arlen,
  input  logic [2:0]             arsize,
  input  logic [1:0]             arburst,
  // Read data
  output logic                   rvalid,
  input  logic                   rready,
  output logic [DATA_SIZE-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   rlast
);

  localparam int unsigned Depth = MEM_SIZE / 4;
  localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [ADDR_SIZE:0] LimitAddr =
      (ADDR_SIZE+1)'(BASE_ADDR) + (ADDR_SIZE+1)'(MEM_SIZE);

  function automatic logic [IdxW-1:0] word_index(input logic [ADDR_SIZE-1:0] a);
    return IdxW'((a - BASE_ADDR) >> 2);
  endfunction

  // Burst falls partly or wholly outside the backed window.
  function automatic logic range_err(input logic [ADDR_SIZE-1:0] a, input logic [7:0] l);
    logic [ADDR_SIZE:0] end_addr;
    end_addr = {1'b0, a} + (ADDR_SIZE+1)'({l, 2'b00}) + (ADDR_SIZE+1)'(4);
    return (a < BASE_ADDR) || (end_addr > LimitAddr);
  endfunction

  axi_mem_state_t state_q, state_d;
  logic           ready_en_q;  // holds the idle readies low until the first edge out of reset
  logic           rr_q, rr_d;  // 0: a collision grants read, 1: grants write
  logic           err_q, err_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     beat_q, beat_d;
  logic [IdxW-1:0] word_q, word_d;

  logic            ar_hs, aw_hs, r_hs, w_hs, b_hs, last_beat;
  logic [IdxW-1:0] ram_addr;
  logic            ram_we;
  logic [DATA_SIZE-1:0] ram_rdata;

  logic unused_size_burst;
  assign unused_size_burst = ^{awsize, awburst, arsize, arburst};

  assign ar_hs     = arvalid && arready;
  assign aw_hs     = awvalid && awready;
  assign r_hs      = rvalid && rready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign last_beat = (beat_q == len_q);

  // State register.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ar_hs) begin
          state_d = StRdAddr;
        end else if (aw_hs) begin
          state_d = StWrData;
        end
      end
      StRdAddr: state_d = StRdData;
      StRdData: if (r_hs && last_beat) state_d = StIdle;
      StWrData: if (w_hs && last_beat) state_d = StWrResp;
      StWrResp: if (b_hs) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Channel outputs; the losing side of a collision sees its ready low.
  always_comb begin
    logic idle_ready;
    logic both;
    idle_ready = (state_q == StIdle) && ready_en_q;
    both       = arvalid && awvalid;
    arready    = idle_ready && !(both && rr_q);
    awready    = idle_ready && !(both && !rr_q);
    wready     = (state_q == StWrData);
    bvalid     = (state_q == StWrResp);
    bresp      = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    rvalid     = (state_q == StRdData);
    rlast      = rvalid && last_beat;
    rresp      = (rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    rdata      = (rvalid && !err_q) ? ram_rdata : '0;
  end

  // Burst bookkeeping: capture on address handshake, advance per data beat.
  always_comb begin
    rr_d   = rr_q;
    err_d  = err_q;
    len_d  = len_q;
    beat_d = beat_q;
    word_d = word_q;
    if (ar_hs) begin
      rr_d   = ~rr_q;
      err_d  = range_err(araddr, arlen);
      len_d  = arlen;
      beat_d = '0;
      word_d = word_index(araddr);
    end else if (aw_hs) begin
      rr_d   = ~rr_q;
      err_d  = range_err(awaddr, awlen);
      len_d  = awlen;
      beat_d = '0;
      word_d = word_index(awaddr);
    end
    if (r_hs || w_hs) begin
      beat_d = beat_q + 8'd1;
      word_d = word_q + IdxW'(1);
    end
    if (w_hs && (wlast != last_beat)) begin
      err_d = 1'b1;
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      ready_en_q <= 1'b0;
      rr_q       <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= '0;
      beat_q     <= '0;
      word_q     <= '0;
    end else begin
      ready_en_q <= 1'b1;
      rr_q       <= rr_d;
      err_q      <= err_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      word_q     <= word_d;
    end
  end

  // Prefetch the next word on a read handshake so rready rising never bubbles.
  assign ram_addr = (state_q == StRdData && r_hs) ? word_q + IdxW'(1) : word_q;
  assign ram_we   = w_hs && !err_q;

  axi_mem_slave_bram_be #(
    .Depth (Depth),
    .Width (DATA_SIZE),
    .AddrW (IdxW)
  ) u_ram (
    .clk   (i_aclk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (wstrb),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: read beats and write responses are
// predicted into queues at stimulus time and compared as the DUT emits them.
module tb_axi_mem_slave;
  import axi_mem_slave_pkg::*;

  localparam int unsigned MEM = 2**16;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        awvalid = 0, awready;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic        wvalid = 0, wready, wlast = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b1;
  logic [1:0]  bresp;
  logic        arvalid = 0, arready;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic        rvalid, rready = 1'b1, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  rbeat_t      rq[$];
  logic [1:0]  bq[$];
  logic [31:0] model [int];

  bit          r_stalled = 0;
  logic [32:0] r_held;

  axi_mem_slave #(
    .ADDR_SIZE (32),
    .MEM_SIZE  (MEM),
    .BASE_ADDR (32'h0)
  ) dut (
    .i_aclk   (aclk),
    .i_areset (areset),
    .awvalid  (awvalid),
    .awready  (awready),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (3'd2),
    .awburst  (2'b01),
    .wvalid   (wvalid),
    .wready   (wready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .bvalid   (bvalid),
    .bready   (bready),
    .bresp    (bresp),
    .arvalid  (arvalid),
    .arready  (arready),
    .araddr   (araddr),
    .arlen    (arlen),
    .arsize   (3'd2),
    .arburst  (2'b01),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rlast    (rlast)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: pop and compare on every R/B handshake, check R hold under stall.
  always @(negedge aclk) begin
    rbeat_t er;
    logic [1:0] eb;
    if (areset) begin
      r_stalled = 0;
    end else begin
      if (rvalid) begin
        if (r_stalled) begin
          vectors++;
          if ({rdata, rlast} !== r_held) begin
            miscompares++;
            $display("FAIL r_hold: rdata/rlast %h, required %h", {rdata, rlast}, r_held);
          end
        end
        r_stalled = !rready;
        r_held    = {rdata, rlast};
      end else begin
        r_stalled = 0;
      end
      if (rvalid && rready) begin
        vectors++;
        if (rq.size() == 0) begin
          miscompares++;
          $display("FAIL r_beat: unexpected beat data %h", rdata);
        end else begin
          er = rq.pop_front();
          if ({rdata, rresp, rlast} !== {er.data, er.resp, er.last}) begin
            miscompares++;
            $display("FAIL r_beat: data/resp/last %h/%b/%b, required %h/%b/%b",
                     rdata, rresp, rlast, er.data, er.resp, er.last);
          end
        end
      end
      if (bvalid && bready) begin
        vectors++;
        if (bq.size() == 0) begin
          miscompares++;
          $display("FAIL b_resp: unexpected response %b", bresp);
        end else begin
          eb = bq.pop_front();
          if (bresp !== eb) begin
            miscompares++;
            $display("FAIL b_resp: bresp %b, required %b", bresp, eb);
          end
        end
      end
    end
  end

  function automatic bit model_err(input logic [31:0] a, input logic [7:0] l);
    longint unsigned end_addr;
    end_addr = longint'(a) + 4 * (longint'(l) + 1);
    return end_addr > longint'(MEM);
  endfunction

  // Predict memory effect and write response of a burst.
  task automatic model_write(input logic [31:0] a, input logic [7:0] l, input logic [31:0] base,
                             input logic [3:0] strb, input int wlast_beat);
    bit e;
    logic [31:0] w, d;
    int idx;
    e = model_err(a, l);
    for (int b = 0; b <= int'(l); b++) begin
      idx = int'(a >> 2) + b;
      d = base + b;
      if (!e) begin
        w = model.exists(idx) ? model[idx] : 32'hx;
        for (int k = 0; k < 4; k++) if (strb[k]) w[k*8 +: 8] = d[k*8 +: 8];
        model[idx] = w;
      end
      if ((b == wlast_beat) != (b == int'(l))) e = 1;
    end
    bq.push_back(e ? RESP_SLVERR : RESP_OKAY);
  endtask

  task automatic model_read(input logic [31:0] a, input logic [7:0] l);
    rbeat_t x;
    bit e;
    e = model_err(a, l);
    for (int b = 0; b <= int'(l); b++) begin
      x.last = (b == int'(l));
      if (e) begin
        x.data = '0;
        x.resp = RESP_SLVERR;
      end else begin
        x.data = model[int'(a >> 2) + b];
        x.resp = RESP_OKAY;
      end
      rq.push_back(x);
    end
  endtask

  task automatic run_write(input logic [31:0] a, input logic [7:0] l, input logic [31:0] base,
                           input logic [3:0] strb, input int wlast_beat, output int accepted);
    int n;
    int b;
    model_write(a, l, base, strb, wlast_beat);
    @(posedge aclk); #1;
    awvalid = 1; awaddr = a; awlen = l;
    n = 0;
    do begin @(negedge aclk); n++; end while (!awready && n < 20);
    vectors++;
    if (!awready) begin
      miscompares++;
      $display("FAIL aw_timeout: awready %b, required 1", awready);
      awvalid = 0; bq.delete(); accepted = 0;
      return;
    end
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 1; wdata = base; wstrb = strb; wlast = (wlast_beat == 0);
    @(negedge aclk);
    vectors++;
    if (wready !== 1'b1) begin
      miscompares++;
      $display("FAIL w_latency: wready %b one cycle after AW, required 1", wready);
    end
    b = 0; n = 0;
    while (b <= int'(l) && n < 200) begin
      if (wready) b++;
      @(posedge aclk); #1;
      if (b <= int'(l)) begin
        wdata = base + b;
        wlast = (b == wlast_beat);
      end else begin
        wvalid = 0; wlast = 0;
      end
      @(negedge aclk); n++;
    end
    wvalid = 0;
    accepted = b;
    vectors++;
    if (bvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL b_latency: bvalid %b one cycle after last W, required 1", bvalid);
    end
    n = 0;
    while (bq.size() != 0 && n < 20) begin @(posedge aclk); #1; n++; end
    @(negedge aclk);
    vectors++;
    if ({awready, arready} !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_write: aw/arready %b, required 11", {awready, arready});
    end
  endtask

  task automatic run_read(input logic [31:0] a, input logic [7:0] l, input bit toggle,
                          output int span);
    int n, lat, c0, c1;
    bit done;
    model_read(a, l);
    @(posedge aclk); #1;
    arvalid = 1; araddr = a; arlen = l; rready = toggle ? 1'b0 : 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!arready && n < 20);
    vectors++;
    if (!arready) begin
      miscompares++;
      $display("FAIL ar_timeout: arready %b, required 1", arready);
      arvalid = 0; rq.delete(); rready = 1; span = 0;
      return;
    end
    c0 = cyc;
    @(posedge aclk); #1;
    arvalid = 0;
    if (toggle) rready = ~rready;
    lat = 1;
    @(negedge aclk);
    while (!rvalid && lat < 20) begin
      @(posedge aclk); #1;
      if (toggle) rready = ~rready;
      @(negedge aclk); lat++;
    end
    vectors++;
    if (lat != 2) begin
      miscompares++;
      $display("FAIL r_latency: first rvalid %0d cycles after AR, required 2", lat);
    end
    done = 0; n = 0; c1 = c0;
    while (!done && n < 400) begin
      if (rvalid && rready && rlast) begin done = 1; c1 = cyc; end
      @(posedge aclk); #1;
      if (toggle) rready = ~rready;
      @(negedge aclk); n++;
    end
    rready = 1;
    span = c1 - c0 + 1;
    vectors++;
    if (!done || rq.size() != 0) begin
      miscompares++;
      $display("FAIL r_burst: done %b pending %0d, required 1 and 0", done, rq.size());
    end
    vectors++;
    if (arready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_read: arready %b after last R, required 1", arready);
    end
  endtask

  task automatic pulse_reset();
    @(posedge aclk); #1; areset = 1;
    repeat (2) @(posedge aclk);
    #1; areset = 0;
    repeat (2) @(posedge aclk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge aclk);
    vectors++; if (awready !== 0) begin miscompares++; $display("FAIL rst_awready: %b, required 0", awready); end
    vectors++; if (arready !== 0) begin miscompares++; $display("FAIL rst_arready: %b, required 0", arready); end
    vectors++; if (wready !== 0) begin miscompares++; $display("FAIL rst_wready: %b, required 0", wready); end
    vectors++; if (bvalid !== 0) begin miscompares++; $display("FAIL rst_bvalid: %b, required 0", bvalid); end
    vectors++; if (rvalid !== 0) begin miscompares++; $display("FAIL rst_rvalid: %b, required 0", rvalid); end
    vectors++; if (rlast !== 0) begin miscompares++; $display("FAIL rst_rlast: %b, required 0", rlast); end
    vectors++; if (rdata !== 0) begin miscompares++; $display("FAIL rst_rdata: %h, required 0", rdata); end
    vectors++; if (rresp !== 0) begin miscompares++; $display("FAIL rst_rresp: %b, required 0", rresp); end
    vectors++; if (bresp !== 0) begin miscompares++; $display("FAIL rst_bresp: %b, required 0", bresp); end
    @(posedge aclk); #1; areset = 0;
    @(negedge aclk);
    vectors++;
    if ({arready, awready} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_release: readies %b before first edge, required 00", {arready, awready});
    end
    @(negedge aclk);
    vectors++;
    if ({arready, awready} !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_ready_rise: readies %b, required 11", {arready, awready});
    end
  endtask

  task automatic test_write_read_line();
    int acc, span;
    run_write(32'h100, 8'd3, 32'hA0, 4'hF, 3, acc);
    run_read(32'h100, 8'd3, 1'b0, span);
  endtask

  task automatic test_strobe_backpressure();
    int acc, span;
    run_write(32'h40, 8'd1, 32'h11223344, 4'hF, 1, acc);
    run_write(32'h40, 8'd0, 32'hFFFFFFFF, 4'b0101, 0, acc);
    run_read(32'h40, 8'd1, 1'b1, span);
  endtask

  task automatic collide(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd,
                         input bit read_first);
    int n;
    bit ar_done, aw_done, w_done, r_done, b_done, first_set, first_is_read;
    ar_done = 0; aw_done = 0; w_done = 0; r_done = 0; b_done = 0;
    first_set = 0; first_is_read = 0;
    model_read(ra, 8'd0);
    model_write(wa, 8'd0, wd, 4'hF, 0);
    @(posedge aclk); #1;
    arvalid = 1; araddr = ra; arlen = 0; rready = 1;
    awvalid = 1; awaddr = wa; awlen = 0;
    wvalid = 1; wdata = wd; wstrb = 4'hF; wlast = 1;
    @(negedge aclk);
    vectors++;
    if (arready !== read_first) begin
      miscompares++;
      $display("FAIL arb_arready: %b, required %b", arready, read_first);
    end
    vectors++;
    if (awready !== !read_first) begin
      miscompares++;
      $display("FAIL arb_awready: %b, required %b", awready, !read_first);
    end
    n = 0;
    while (!(r_done && b_done) && n < 60) begin
      if (arvalid && arready) begin
        ar_done = 1;
        if (!first_set) begin first_set = 1; first_is_read = 1; end
      end
      if (awvalid && awready) begin
        aw_done = 1;
        if (!first_set) begin first_set = 1; first_is_read = 0; end
      end
      if (wvalid && wready) w_done = 1;
      if (rvalid && rready && rlast) r_done = 1;
      if (bvalid && bready) b_done = 1;
      @(posedge aclk); #1;
      if (ar_done) arvalid = 0;
      if (aw_done) awvalid = 0;
      if (w_done) begin wvalid = 0; wlast = 0; end
      @(negedge aclk); n++;
    end
    arvalid = 0; awvalid = 0; wvalid = 0;
    vectors++;
    if (!(r_done && b_done)) begin
      miscompares++;
      $display("FAIL arb_done: read %b write %b, required 1 1", r_done, b_done);
    end
    vectors++;
    if (first_is_read !== read_first) begin
      miscompares++;
      $display("FAIL arb_order: read first %b, required %b", first_is_read, read_first);
    end
  endtask

  task automatic test_arbitration();
    int span;
    pulse_reset();
    collide(32'h100, 32'h200, 32'h5A5A0001, 1'b1);
    // Read then write left the bit favouring read; one more read turns it to write.
    run_read(32'h200, 8'd0, 1'b0, span);
    collide(32'h104, 32'h204, 32'h5A5A0002, 1'b0);
    run_read(32'h204, 8'd0, 1'b0, span);
  endtask

  task automatic test_error_window();
    int acc, span;
    run_write(MEM - 8, 8'd1, 32'hC0DE0000, 4'hF, 1, acc);
    run_read(MEM - 8, 8'd3, 1'b0, span);
    run_write(MEM - 8, 8'd3, 32'hBAD00000, 4'hF, 3, acc);
    run_read(MEM - 8, 8'd1, 1'b0, span);
  endtask

  task automatic test_wlast_mismatch();
    int acc;
    run_write(32'h300, 8'd3, 32'h33000000, 4'hF, 1, acc);
    vectors++;
    if (acc != 4) begin
      miscompares++;
      $display("FAIL wlast_beats: accepted %0d, required 4", acc);
    end
  endtask

  task automatic test_back_to_back();
    int acc, span;
    run_write(32'h800, 8'd15, 32'h30000000, 4'hF, 15, acc);
    run_read(32'h800, 8'd15, 1'b0, span);
    vectors++;
    if (span != 18) begin
      miscompares++;
      $display("FAIL read16_span: %0d cycles, required 18", span);
    end
  endtask

  task automatic test_mid_burst_reset();
    int acc, span, n, beats;
    run_write(32'h400, 8'd7, 32'h77000000, 4'hF, 7, acc);
    model_read(32'h400, 8'd7);
    @(posedge aclk); #1;
    arvalid = 1; araddr = 32'h400; arlen = 8'd7; rready = 1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!arready && n < 20);
    @(posedge aclk); #1;
    arvalid = 0;
    beats = 0; n = 0;
    @(negedge aclk);
    while (n < 40 && !(rvalid && beats == 2)) begin
      if (rvalid) beats++;
      @(negedge aclk); n++;
    end
    #2 areset = 1;
    #1;
    vectors++;
    if ({rvalid, arready, awready, wready, bvalid} !== 5'b0) begin
      miscompares++;
      $display("FAIL mid_reset: rvalid/ar/aw/w/bvalid %b, required 00000",
               {rvalid, arready, awready, wready, bvalid});
    end
    rq.delete();
    @(posedge aclk); #1;
    @(posedge aclk); #1; areset = 0;
    @(negedge aclk);
    @(negedge aclk);
    vectors++;
    if (arready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_ready: arready %b, required 1", arready);
    end
    run_read(32'h400, 8'd7, 1'b0, span);
  endtask

  initial begin
    test_reset();
    test_write_read_line();
    test_strobe_backpressure();
    test_arbitration();
    test_error_window();
    test_wlast_mismatch();
    test_back_to_back();
    test_mid_burst_reset();
    repeat (3) @(posedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
